// File: rtl/delay_pkg.sv
// Shared definitions for the sample delay-line controller: default
// geometry constants and the controller FSM state type.
package delay_pkg;

  localparam int DEF_DATA_WIDTH = 31;
  localparam int DEF_ADDR_WIDTH = 15;
  localparam int DEF_SIZE       = 20000;
  localparam int DEF_READ_LAT   = 2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    OUTPUT
  } state_t;

endpackage

// File: rtl/delay_addr_gen.sv
// Read address generator for the circular delay buffer. The buffer depth
// is not a power of two, so the wrap is done explicitly against SIZE
// instead of relying on modulo-2^ADDR_WIDTH arithmetic.
module delay_addr_gen
  import delay_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int SIZE       = DEF_SIZE
) (
  input  logic [ADDR_WIDTH-1:0] wr_ptr,
  input  logic [ADDR_WIDTH-1:0] d,
  output logic [ADDR_WIDTH-1:0] rd_addr
);

  localparam logic [ADDR_WIDTH-1:0] SIZE_A = ADDR_WIDTH'(SIZE);

  // Step back d samples from the write pointer, wrapping past address 0
  // to the top of the buffer; SIZE-d is formed first so nothing overflows.
  always_comb begin
    if (wr_ptr >= d) rd_addr = wr_ptr - d;
    else             rd_addr = wr_ptr + (SIZE_A - d);
  end

endmodule

// File: rtl/delay_ctrl.sv
// Delay-line controller: writes each accepted sample into an external
// dual-port memory and reads back the sample written D samples earlier.
// One sample is in flight at a time (IDLE -> ISSUE -> WAIT -> OUTPUT).
module delay_ctrl
  import delay_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int SIZE       = DEF_SIZE,
  parameter int READ_LAT   = DEF_READ_LAT
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  input  logic [ADDR_WIDTH-1:0] DELAY,
  output logic                  OUT_VALID,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic                  OVERRUN,
  input  logic                  OVR_CLR,
  output logic                  MEM_WE,
  output logic [ADDR_WIDTH-1:0] MEM_WADDR,
  output logic [ADDR_WIDTH-1:0] MEM_RADDR,
  output logic [DATA_WIDTH-1:0] MEM_DI,
  input  logic [DATA_WIDTH-1:0] MEM_DO
);

  localparam logic [ADDR_WIDTH-1:0] MAX_D     = ADDR_WIDTH'(SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam int                    CNT_W     = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [CNT_W-1:0]      WAIT_INIT = CNT_W'(READ_LAT - 1);
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   wr_ptr;
  logic [ADDR_WIDTH-1:0]   fill;
  logic [ADDR_WIDTH-1:0]   d_lat;
  logic [ADDR_WIDTH-1:0]   d_eff;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [DATA_WIDTH-1:0]   data_lat;
  logic [CNT_W-1:0]        wait_cnt;

  assign d_eff    = (DELAY > MAX_D) ? MAX_D : DELAY;
  assign IN_READY = (state == IDLE);

  delay_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .SIZE       (SIZE)
  ) u_addr_gen (
    .wr_ptr  (wr_ptr),
    .d       (d_eff),
    .rd_addr (rd_addr)
  );

  // Sample sequencing; memory strobes and OUT_* are registered so they are
  // valid in the state they belong to (set on the edge entering that state).
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      fill      <= '0;
      d_lat     <= '0;
      data_lat  <= '0;
      wait_cnt  <= '0;
      OUT_VALID <= 1'b0;
      OUT_DATA  <= '0;
      MEM_WE    <= 1'b0;
      MEM_WADDR <= '0;
      MEM_RADDR <= '0;
      MEM_DI    <= '0;
    end else begin
      OUT_VALID <= 1'b0;
      unique case (state)
        IDLE: begin
          if (IN_VALID) begin
            data_lat  <= IN_DATA;
            d_lat     <= d_eff;
            MEM_WE    <= 1'b1;
            MEM_WADDR <= wr_ptr;
            MEM_DI    <= IN_DATA;
            MEM_RADDR <= rd_addr;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          MEM_WE   <= 1'b0;
          wait_cnt <= WAIT_INIT;
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            OUT_VALID <= 1'b1;
            if (d_lat == '0)       OUT_DATA <= data_lat;
            else if (fill < d_lat) OUT_DATA <= '0;
            else                   OUT_DATA <= MEM_DO;
            state <= OUTPUT;
          end else begin
            wait_cnt <= wait_cnt - CNT_ONE;
          end
        end
        OUTPUT: begin
          wr_ptr <= (wr_ptr == MAX_D) ? '0 : wr_ptr + ADDR_ONE;
          if (fill != MAX_D) fill <= fill + ADDR_ONE;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky drop flag; a new drop in the same cycle as a clear keeps it set.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                    OVERRUN <= 1'b0;
    else if (IN_VALID && !IN_READY) OVERRUN <= 1'b1;
    else if (OVR_CLR)              OVERRUN <= 1'b0;
  end

endmodule
